fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Two-requester write arbiter that shares the 8-deep, 16-bit fifo write port between two producers.
- Arbitrates round-robin and drives the fifo's WR/DIN from registers.
- Throttles on FULL/almostFULL so the fifo never sees a write while full.
- Keeps per-requester accepted-word counters and a sticky overflow error flag; sits directly in front of the fifo in the same clock domain.

Parameters:
- DW, 16, data width of DIN0/DIN1/FIFO_DIN (matches fifo DIN).
- CW, 8, width of the accepted-word counters CNT0/CNT1.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-low (RST=0 resets at the next rising CLK edge).
- EN  in  1  arbitration enable; 0 pauses all grants.
- REQ0  in  1  requester 0 has a word on DIN0.
- DIN0  in  DW  requester 0 data; held stable while REQ0=1 and ACK0=0.
- ACK0  out  1  combinational; requester 0's word is accepted at this rising edge.
- REQ1  in  1  requester 1 request.
- DIN1  in  DW  requester 1 data.
- ACK1  out  1  combinational accept for requester 1.
- FIFO_FULL  in  1  from fifo FULL.
- FIFO_AFULL  in  1  from fifo almostFULL; asserted when exactly one free slot remains.
- FIFO_OVER  in  1  from fifo OVER.
- FIFO_WR  out  1  registered write strobe to fifo WR.
- FIFO_DIN  out  DW  registered data to fifo DIN.
- STALL  out  1  registered; 1 while the controller is in STALL.
- CNT0  out  CW  words accepted from requester 0.
- CNT1  out  CW  words accepted from requester 1.
- ERR  out  1  sticky; set when FIFO_OVER=1 is sampled.

Behaviour:
- Reset (RST=0 at an edge): FIFO_WR=0, FIFO_DIN=0, STALL=0, CNT0=CNT1=0, ERR=0, PRIO=0, state=IDLE.
- While RST=0, ACK0=ACK1=0 combinationally, regardless of other inputs.
- Blocked condition: blk = FIFO_FULL | (FIFO_AFULL & FIFO_WR). This accounts for the write already in flight; the fifo must never receive WR while FULL.
- States:
  - IDLE: EN=0; no grants.
  - ARB: EN=1 and blk=0; grants allowed.
  - STALL: EN=1 and blk=1; no grants.
- Transitions are evaluated every cycle from EN and blk, with priority IDLE > STALL > ARB. STALL output = (next state == STALL), registered.
- Grant is computed combinationally and only in a cycle where EN=1, blk=0 and RST=1:
  - Only REQ0 set: grant 0.
  - Only REQ1 set: grant 1.
  - Both set: grant PRIO (0 means requester 0 wins).
- ACKx = grant to x.
- On the edge where ACKx=1:
  - FIFO_WR<=1, FIFO_DIN<=DINx.
  - PRIO<= the other requester (1-x).
  - CNTx<=CNTx+1, wrapping (2^CW - 1) to 0.
- On an edge with no grant: FIFO_WR<=0, FIFO_DIN holds, PRIO holds.
- Latency: the word appears on FIFO_WR/FIFO_DIN one cycle after its ACK.
- Throughput: one word per cycle, with strict alternation when both requesters are active.
- Requester rule: a requester whose REQ stays high after ACK offers its next word; DIN must already hold the next word.
- A requester that drops REQ before ACK loses nothing; no grant is remembered.
- ERR<=1 on any edge with FIFO_OVER=1. It clears only on reset.
- Fifo read side is untouched by this block.
- Reset asserted mid-burst: the pending registered write is dropped, with FIFO_WR=0 after the reset edge. The fifo is reset by the same signal.

Test Plan:
- Reset: hold RST=0 for 2 cycles with REQ0=REQ1=1 and EN=1 -> ACK0=ACK1=0 throughout; after the edge FIFO_WR=0, CNT0=CNT1=0, ERR=0, STALL=0.
- Single requester: EN=1, REQ0=1, DIN0=16'h1111/16'h2222/16'h3333 on successive ACKs, fifo empty -> ACK0 high 3 consecutive cycles; FIFO_WR=1 for 3 cycles one cycle later carrying 1111, 2222, 3333; CNT0=3.
- Contention: both REQ high for 4 grants, DIN0=16'hA000+n, DIN1=16'hB000+n -> grant order 0,1,0,1; FIFO_DIN sequence A000, B000, A001, B001; CNT0=CNT1=2.
- Full throttle: REQ0 held high from an empty fifo, reads disabled -> exactly 8 writes accepted; FIFO_AFULL & FIFO_WR blocks the 9th cycle; STALL=1; FIFO_OVER never asserts; ERR=0. Then one RD -> FULL drops -> exactly 1 more word is written.
- Pause: deassert EN mid-stream -> no ACK from the next cycle; FIFO_WR=0 one cycle later. Re-enable with both REQ high -> the grant goes to PRIO as left by the last accepted word.
- Counter wrap and error: force 256 accepts from requester 1 -> CNT1 returns to 0. Drive FIFO_OVER=1 for one cycle -> ERR=1 stays set until RST=0.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Two-requester round-robin write arbiter in front of an 8-deep fifo.
// Throttles on FULL/almostFULL so no write ever reaches a full fifo.
module fifo_wr_arb #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          REQ0,
  input  logic [DW-1:0] DIN0,
  output logic          ACK0,
  input  logic          REQ1,
  input  logic [DW-1:0] DIN1,
  output logic          ACK1,
  input  logic          FIFO_FULL,
  input  logic          FIFO_AFULL,
  input  logic          FIFO_OVER,
  output logic          FIFO_WR,
  output logic [DW-1:0] FIFO_DIN,
  output logic          STALL,
  output logic [CW-1:0] CNT0,
  output logic [CW-1:0] CNT1,
  output logic          ERR
);

  typedef enum logic [1:0] {StIdle, StArb, StStall} state_e;

  state_e state_q, state_d;
  logic   prio_q;
  logic   blk;
  logic   go;

  // A write already in flight consumes the last free slot.
  assign blk = FIFO_FULL | (FIFO_AFULL & FIFO_WR);
  assign go  = RST & EN & ~blk;

  assign ACK0 = go & REQ0 & (~REQ1 | ~prio_q);
  assign ACK1 = go & REQ1 & (~REQ0 | prio_q);

  assign STALL = (state_q == StStall);

  always_comb begin
    state_d = StArb;
    if (!EN) begin
      state_d = StIdle;
    end else if (blk) begin
      state_d = StStall;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      FIFO_WR  <= 1'b0;
      FIFO_DIN <= '0;
      CNT0     <= '0;
      CNT1     <= '0;
      ERR      <= 1'b0;
    end else begin
      state_q <= state_d;
      FIFO_WR <= ACK0 | ACK1;
      if (ACK0) begin
        FIFO_DIN <= DIN0;
        prio_q   <= 1'b1;
        CNT0     <= CNT0 + CW'(1);
      end else if (ACK1) begin
        FIFO_DIN <= DIN1;
        prio_q   <= 1'b0;
        CNT1     <= CNT1 + CW'(1);
      end
      if (FIFO_OVER) begin
        ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed self-checking bench for fifo_wr_arb with a small 8-deep fifo occupancy model.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst, en, req0, req1;
  logic [15:0] din0, din1;
  logic        ack0, ack1;
  logic        ffull, fafull, fover;
  logic        fwr;
  logic [15:0] fdin;
  logic        stall;
  logic [7:0]  cnt0, cnt1;
  logic        err;

  logic        rd_en;
  logic        over_f;
  int          fcnt;
  logic        rd_do;
  logic        wr_ok;

  int ntests = 0;
  int nfail  = 0;
  int acks;
  int n0, n1;

  logic [15:0] exp_din [4] = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
  logic        exp_g   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  fifo_wr_arb #(.DW(16), .CW(8)) dut (
    .CLK        (clk),
    .RST        (rst),
    .EN         (en),
    .REQ0       (req0),
    .DIN0       (din0),
    .ACK0       (ack0),
    .REQ1       (req1),
    .DIN1       (din1),
    .ACK1       (ack1),
    .FIFO_FULL  (ffull),
    .FIFO_AFULL (fafull),
    .FIFO_OVER  (fover),
    .FIFO_WR    (fwr),
    .FIFO_DIN   (fdin),
    .STALL      (stall),
    .CNT0       (cnt0),
    .CNT1       (cnt1),
    .ERR        (err)
  );

  // Fifo occupancy model; it shares the arbiter's reset.
  assign rd_do  = rd_en && (fcnt > 0);
  assign wr_ok  = fwr && ((fcnt < 8) || rd_do);
  assign ffull  = (fcnt == 8);
  assign fafull = (fcnt == 7);
  assign fover  = over_f | (fwr && (fcnt == 8) && !rd_do);

  always @(posedge clk) begin
    if (!rst) fcnt <= 0;
    else      fcnt <= fcnt + int'(wr_ok) - int'(rd_do);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; req0 = 1'b1; req1 = 1'b1;
    din0 = 16'h0; din1 = 16'h0; rd_en = 1'b0; over_f = 1'b0;

    // Reset held for two edges with both requesters active
    #1;
    chk("rst_ack0_a", 32'(ack0), 0);
    chk("rst_ack1_a", 32'(ack1), 0);
    tick();
    chk("rst_ack0_b", 32'(ack0), 0);
    chk("rst_ack1_b", 32'(ack1), 0);
    tick();
    chk("rst_ack_c", 32'({ack0, ack1}), 0);
    chk("rst_wr", 32'(fwr), 0);
    chk("rst_din", 32'(fdin), 0);
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_cnt1", 32'(cnt1), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_stall", 32'(stall), 0);
    req0 = 1'b0; req1 = 1'b0; rst = 1'b1;
    tick();

    // Single requester: three back-to-back words
    req0 = 1'b1; din0 = 16'h1111; #1;
    chk("single_ack_1", 32'(ack0), 1);
    tick();
    chk("single_wr_1", 32'(fwr), 1);
    chk("single_din_1", 32'(fdin), 32'h1111);
    din0 = 16'h2222; #1;
    chk("single_ack_2", 32'(ack0), 1);
    tick();
    chk("single_din_2", 32'(fdin), 32'h2222);
    din0 = 16'h3333; #1;
    chk("single_ack_3", 32'(ack0), 1);
    tick();
    chk("single_wr_3", 32'(fwr), 1);
    chk("single_din_3", 32'(fdin), 32'h3333);
    chk("single_cnt0", 32'(cnt0), 3);
    req0 = 1'b0; #1;
    chk("single_ack_off", 32'(ack0), 0);
    tick();
    chk("single_wr_off", 32'(fwr), 0);

    // Contention: strict alternation starting at requester 0
    do_reset();
    n0 = 0; n1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      din0 = 16'hA000 + 16'(n0);
      din1 = 16'hB000 + 16'(n1);
      #1;
      chk("cont_ack0", 32'(ack0), 32'(!exp_g[n]));
      chk("cont_ack1", 32'(ack1), 32'(exp_g[n]));
      if (exp_g[n]) n1++;
      else          n0++;
      tick();
      chk("cont_din", 32'(fdin), 32'(exp_din[n]));
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_cnt0", 32'(cnt0), 2);
    chk("cont_cnt1", 32'(cnt1), 2);

    // Full throttle: empty fifo, no reads, requester 0 streaming
    do_reset();
    req0 = 1'b1; acks = 0;
    for (int i = 0; i < 12; i++) begin
      din0 = 16'hC000 + 16'(acks);
      #1;
      acks += int'(ack0);
      tick();
    end
    chk("full_acks", 32'(acks), 8);
    chk("full_cnt0", 32'(cnt0), 8);
    chk("full_stall", 32'(stall), 1);
    chk("full_ffull", 32'(ffull), 1);
    chk("full_last_din", 32'(fdin), 32'hC007);
    chk("full_err", 32'(err), 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      din0 = 16'hC008; #1;
      acks += int'(ack0);
      tick();
    end
    chk("full_more_acks", 32'(acks), 1);
    chk("full_cnt0_b", 32'(cnt0), 9);
    chk("full_stall_b", 32'(stall), 1);
    chk("full_err_b", 32'(err), 0);
    req0 = 1'b0;

    // Pause mid-stream, then resume with both requesting
    do_reset();
    rd_en = 1'b1;
    req0 = 1'b1; din0 = 16'hD000; #1;
    chk("pause_ack_a", 32'(ack0), 1);
    tick();
    din0 = 16'hD001; #1;
    chk("pause_ack_b", 32'(ack0), 1);
    tick();
    chk("pause_din_b", 32'(fdin), 32'hD001);
    en = 1'b0; #1;
    chk("pause_ack_off", 32'(ack0), 0);
    tick();
    chk("pause_wr_off", 32'(fwr), 0);
    chk("pause_din_hold", 32'(fdin), 32'hD001);
    chk("pause_stall", 32'(stall), 0);
    req1 = 1'b1; din1 = 16'hE000; en = 1'b1; #1;
    chk("resume_ack1", 32'(ack1), 1);
    chk("resume_ack0", 32'(ack0), 0);
    tick();
    chk("resume_din", 32'(fdin), 32'hE000);
    req0 = 1'b0; req1 = 1'b0;

    // Counter wrap on requester 1, fifo drained continuously
    do_reset();
    req1 = 1'b1; acks = 0;
    for (int i = 0; i < 255; i++) begin
      din1 = 16'(i); #1;
      acks += int'(ack1);
      tick();
    end
    chk("wrap_cnt1_255", 32'(cnt1), 255);
    #1;
    acks += int'(ack1);
    tick();
    chk("wrap_acks", 32'(acks), 256);
    chk("wrap_cnt1_0", 32'(cnt1), 0);
    chk("wrap_cnt0", 32'(cnt0), 0);
    req1 = 1'b0;

    // Sticky error
    chk("err_pre", 32'(err), 0);
    over_f = 1'b1;
    tick();
    over_f = 1'b0;
    chk("err_set", 32'(err), 1);
    tick();
    tick();
    chk("err_sticky", 32'(err), 1);
    do_reset();
    chk("err_clear", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
